// File: rtl/nasti_read_arbiter.sv
// Two-requester NASTI read arbiter: round-robin AR mux into one registered slave slot,
// source-tagged IDs, R routing by ID MSB and per-requester outstanding-burst limits.
// Optional perf counters are enabled with `define NASTI_READ_ARB_PERF_EN.
module nasti_read_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 64,
  parameter int ID_W            = 5,
  parameter int MAX_OUTSTANDING = 4,
  localparam int AR_W           = ADDR_W + 8 + 3 + ID_W,
  localparam int R_W            = DATA_W + ID_W + 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          m_ar_valid,
  output logic [1:0]          m_ar_ready,
  input  logic [2*AR_W-1:0]   m_ar_bits,
  output logic [1:0]          m_r_valid,
  input  logic [1:0]          m_r_ready,
  output logic [R_W-1:0]      m_r_bits,
  output logic                s_ar_valid,
  input  logic                s_ar_ready,
  output logic [AR_W:0]       s_ar_bits,
  input  logic                s_r_valid,
  output logic                s_r_ready,
  input  logic [R_W:0]        s_r_bits,
  output logic                idle,
  output logic                err_unexpected_r
`ifdef NASTI_READ_ARB_PERF_EN
  ,
  output logic [2*32-1:0]     perf_grants,
  output logic [2*32-1:0]     perf_stall
`endif
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  // Position of the source tag inside the slave-side R bits {data,{src,id},resp,last}.
  localparam int SRC_BIT = ID_W + 3;

  logic                   s_ar_valid_q, s_ar_valid_d;
  logic [AR_W:0]          s_ar_bits_q, s_ar_bits_d;
  logic                   last_grant_q, last_grant_d;
  logic [1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic                   idle_q, idle_d;

  logic                   free_s;
  logic [1:0]             elig_s;
  logic                   grant_v_s;
  logic                   grant_idx_s;
  logic [AR_W-1:0]        req_bits_s;
  logic [AR_W:0]          ar_out_s;
  logic                   sel_s;
  logic                   r_last_hs_s;
  logic                   r_unexp_s;
  logic [1:0]             inc_s;
  logic [1:0]             dec_s;

  // AR eligibility and round-robin grant; a grant is only offered into a free slot.
  always_comb begin
    free_s      = !s_ar_valid_q || s_ar_ready;
    elig_s      = 2'b00;
    grant_v_s   = 1'b0;
    grant_idx_s = 1'b0;
    for (int i = 0; i < 2; i++) begin
      elig_s[i] = m_ar_valid[i] && (cnt_q[i] < CNT_MAX);
    end
    if (free_s) begin
      case (elig_s)
        2'b01: begin
          grant_v_s   = 1'b1;
          grant_idx_s = 1'b0;
        end
        2'b10: begin
          grant_v_s   = 1'b1;
          grant_idx_s = 1'b1;
        end
        2'b11: begin
          grant_v_s   = 1'b1;
          grant_idx_s = ~last_grant_q;
        end
        default: begin
          grant_v_s   = 1'b0;
          grant_idx_s = 1'b0;
        end
      endcase
    end else begin
      grant_v_s   = 1'b0;
      grant_idx_s = 1'b0;
    end
    if (grant_v_s) begin
      m_ar_ready = grant_idx_s ? 2'b10 : 2'b01;
    end else begin
      m_ar_ready = 2'b00;
    end
  end

  // Selected request with the source index spliced in as the new ID MSB.
  always_comb begin
    if (grant_idx_s) begin
      req_bits_s = m_ar_bits[2*AR_W-1:AR_W];
    end else begin
      req_bits_s = m_ar_bits[AR_W-1:0];
    end
    ar_out_s = {req_bits_s[AR_W-1:ID_W], grant_idx_s, req_bits_s[ID_W-1:0]};
  end

  // R pass-through: steer valid/ready by the source tag and strip it from the ID.
  always_comb begin
    sel_s = s_r_bits[SRC_BIT];
    if (s_r_valid) begin
      m_r_valid = sel_s ? 2'b10 : 2'b01;
    end else begin
      m_r_valid = 2'b00;
    end
    s_r_ready   = m_r_ready[sel_s];
    m_r_bits    = {s_r_bits[R_W:SRC_BIT+1], s_r_bits[SRC_BIT-1:0]};
    r_last_hs_s = s_r_valid && s_r_ready && s_r_bits[0];
    // A beat for a requester with nothing in flight is flagged and never decrements.
    r_unexp_s   = s_r_valid && (cnt_q[sel_s] == CNT_ZERO);
  end

  // Next-state for the slave AR slot, grant history, counters and status flags.
  always_comb begin
    s_ar_valid_d = s_ar_valid_q;
    s_ar_bits_d  = s_ar_bits_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    inc_s        = 2'b00;
    dec_s        = 2'b00;
    if (grant_v_s) begin
      s_ar_valid_d = 1'b1;
      s_ar_bits_d  = ar_out_s;
      last_grant_d = grant_idx_s;
    end else if (s_ar_ready) begin
      s_ar_valid_d = 1'b0;
    end else begin
      s_ar_valid_d = s_ar_valid_q;
    end
    for (int i = 0; i < 2; i++) begin
      inc_s[i] = grant_v_s && (grant_idx_s == i[0]);
      dec_s[i] = r_last_hs_s && !r_unexp_s && (sel_s == i[0]);
      case ({inc_s[i], dec_s[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_ONE;
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_ONE;
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
    err_d  = err_q || r_unexp_s;
    idle_d = !s_ar_valid_d && (cnt_d[0] == CNT_ZERO) && (cnt_d[1] == CNT_ZERO);
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_ar_valid_q <= 1'b0;
      s_ar_bits_q  <= {(AR_W+1){1'b0}};
      last_grant_q <= 1'b1;
      cnt_q        <= {(2*CNT_W){1'b0}};
      err_q        <= 1'b0;
      idle_q       <= 1'b1;
    end else begin
      s_ar_valid_q <= s_ar_valid_d;
      s_ar_bits_q  <= s_ar_bits_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      idle_q       <= idle_d;
    end
  end

  assign s_ar_valid       = s_ar_valid_q;
  assign s_ar_bits        = s_ar_bits_q;
  assign idle             = idle_q;
  assign err_unexpected_r = err_q;

`ifdef NASTI_READ_ARB_PERF_EN
  logic [1:0][31:0] perf_grants_q, perf_grants_d;
  logic [1:0][31:0] perf_stall_q, perf_stall_d;

  // Free-running grant and stall counters, wrapping modulo 2^32.
  always_comb begin
    perf_grants_d = perf_grants_q;
    perf_stall_d  = perf_stall_q;
    for (int i = 0; i < 2; i++) begin
      if (inc_s[i]) begin
        perf_grants_d[i] = perf_grants_q[i] + 32'd1;
      end else begin
        perf_grants_d[i] = perf_grants_q[i];
      end
      if (m_ar_valid[i] && !m_ar_ready[i]) begin
        perf_stall_d[i] = perf_stall_q[i] + 32'd1;
      end else begin
        perf_stall_d[i] = perf_stall_q[i];
      end
    end
  end

  // Perf counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_grants_q <= {64{1'b0}};
      perf_stall_q  <= {64{1'b0}};
    end else begin
      perf_grants_q <= perf_grants_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_grants = perf_grants_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_nasti_read_arbiter.sv
// Bench for nasti_read_arbiter: a directed vector table, hand sequences and randomized
// traffic checked against an outstanding-count/slot reference model.
module tb_nasti_read_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int ID_W   = 5;
  localparam int MAXO   = 4;
  localparam int AR_W   = ADDR_W + 8 + 3 + ID_W;
  localparam int R_W    = DATA_W + ID_W + 3;

  logic                clk = 1'b0;
  logic                reset;
  logic [1:0]          m_ar_valid;
  logic [1:0]          m_ar_ready;
  logic [2*AR_W-1:0]   m_ar_bits;
  logic [1:0]          m_r_valid;
  logic [1:0]          m_r_ready;
  logic [R_W-1:0]      m_r_bits;
  logic                s_ar_valid;
  logic                s_ar_ready;
  logic [AR_W:0]       s_ar_bits;
  logic                s_r_valid;
  logic                s_r_ready;
  logic [R_W:0]        s_r_bits;
  logic                idle;
  logic                err_unexpected_r;
`ifdef NASTI_READ_ARB_PERF_EN
  logic [63:0]         perf_grants;
  logic [63:0]         perf_stall;
`endif

  // stimulus fields
  logic [ADDR_W-1:0] a_addr [2];
  logic [7:0]        a_len  [2];
  logic [2:0]        a_size [2];
  logic [ID_W-1:0]   a_id   [2];
  logic              rsrc;
  logic [ID_W-1:0]   rid;
  logic [1:0]        rresp;
  logic              rlast;
  logic [DATA_W-1:0] rdata;

  assign m_ar_bits = {a_addr[1], a_len[1], a_size[1], a_id[1],
                      a_addr[0], a_len[0], a_size[0], a_id[0]};
  assign s_r_bits  = {rdata, rsrc, rid, rresp, rlast};

  nasti_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_bits(m_ar_bits),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_bits(m_r_bits),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_bits(s_ar_bits),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_bits(s_r_bits),
    .idle(idle), .err_unexpected_r(err_unexpected_r)
`ifdef NASTI_READ_ARB_PERF_EN
    , .perf_grants(perf_grants), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // reference model: in-flight burst counts, the slave slot contents, rotation history
  int              outst [2];
  int              last_g;
  bit              slot_v;
  logic [AR_W:0]   slot_b;
  bit              err_m;
  int              grants_m [2];
  int              stalls_m [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      outst[i] = 0; grants_m[i] = 0; stalls_m[i] = 0;
    end
    last_g = 1; slot_v = 1'b0; slot_b = '0; err_m = 1'b0;
  endtask

  task automatic clear_inputs();
    m_ar_valid = 2'b00; s_ar_ready = 1'b0; s_r_valid = 1'b0; m_r_ready = 2'b00;
    for (int i = 0; i < 2; i++) begin
      a_addr[i] = '0; a_len[i] = '0; a_size[i] = '0; a_id[i] = '0;
    end
    rsrc = 1'b0; rid = '0; rresp = 2'b00; rlast = 1'b0; rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_s_ar_valid", 128'(s_ar_valid), 128'(0));
    chk("rst_s_ar_bits", 128'(s_ar_bits), 128'(0));
    chk("rst_idle", 128'(idle), 128'(1));
    chk("rst_err", 128'(err_unexpected_r), 128'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  // Called #1 after a rising edge with inputs already driven: check, then advance model.
  task automatic step();
    bit   fr;
    bit   el [2];
    int   w;
    logic ws;
    logic [1:0] exp_arr;
    #3;
    fr = !slot_v || s_ar_ready;
    for (int i = 0; i < 2; i++) el[i] = m_ar_valid[i] && (outst[i] < MAXO);
    w = -1;
    if (fr && el[0] && el[1]) w = 1 - last_g;
    else if (fr && el[0]) w = 0;
    else if (fr && el[1]) w = 1;
    exp_arr = (w == 0) ? 2'b01 : ((w == 1) ? 2'b10 : 2'b00);
    chk("m_ar_ready", 128'(m_ar_ready), 128'(exp_arr));
    chk("s_ar_valid", 128'(s_ar_valid), 128'(slot_v));
    if (slot_v) chk("s_ar_bits", 128'(s_ar_bits), 128'(slot_b));
    chk("idle", 128'(idle), 128'(!slot_v && outst[0] == 0 && outst[1] == 0));
    chk("err_unexpected_r", 128'(err_unexpected_r), 128'(err_m));
    chk("m_r_valid", 128'(m_r_valid), 128'(s_r_valid ? (rsrc ? 2'b10 : 2'b01) : 2'b00));
    chk("s_r_ready", 128'(s_r_ready), 128'(m_r_ready[rsrc]));
    if (s_r_valid) chk("m_r_bits", 128'(m_r_bits), 128'({rdata, rid, rresp, rlast}));
    for (int i = 0; i < 2; i++) if (m_ar_valid[i] && w != i) stalls_m[i]++;
    if (s_r_valid) begin
      if (outst[rsrc] == 0) err_m = 1'b1;
      else if (m_r_ready[rsrc] && rlast) outst[rsrc]--;
    end
    if (w >= 0) begin
      ws = w[0];
      slot_v = 1'b1;
      slot_b = {a_addr[ws], a_len[ws], a_size[ws], ws, a_id[ws]};
      last_g = w; outst[ws]++; grants_m[ws]++;
    end else if (s_ar_ready) begin
      slot_v = 1'b0;
    end
  endtask

  task automatic cyc(input logic [1:0] arv, input logic sar, input logic rv,
                     input logic src, input logic lst, input logic [1:0] rrdy);
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      a_addr[i] = $urandom; a_len[i] = 8'($urandom); a_size[i] = 3'($urandom);
      a_id[i] = 5'($urandom);
    end
    rdata = {$urandom, $urandom}; rid = 5'($urandom); rresp = 2'($urandom);
    m_ar_valid = arv; s_ar_ready = sar; s_r_valid = rv; rsrc = src; rlast = lst;
    m_r_ready = rrdy;
    step();
  endtask

  typedef struct {
    logic [1:0] arv;  logic sar; logic rv; logic src; logic lst; logic [1:0] rrdy;
    logic [1:0] e_arr; logic e_sv; logic [5:0] e_sid; logic [1:0] e_rv;
    logic e_srr; logic e_idle; logic e_err;
  } vec_t;

  vec_t vt [18];

  initial begin
    //           arv   sar   rv    src   lst   rrdy    arr   sv    sid    rv    srr   idle  err
    vt[0]  = '{2'b00,1'b1,1'b0,1'b0,1'b0,2'b00, 2'b00,1'b0,6'h00,2'b00,1'b0,1'b1,1'b0};
    vt[1]  = '{2'b01,1'b1,1'b0,1'b0,1'b0,2'b00, 2'b01,1'b0,6'h00,2'b00,1'b0,1'b1,1'b0};
    vt[2]  = '{2'b00,1'b0,1'b0,1'b0,1'b0,2'b00, 2'b00,1'b1,6'h05,2'b00,1'b0,1'b0,1'b0};
    vt[3]  = '{2'b00,1'b1,1'b0,1'b0,1'b0,2'b00, 2'b00,1'b1,6'h05,2'b00,1'b0,1'b0,1'b0};
    vt[4]  = '{2'b00,1'b1,1'b1,1'b0,1'b0,2'b01, 2'b00,1'b0,6'h00,2'b01,1'b1,1'b0,1'b0};
    vt[5]  = '{2'b00,1'b1,1'b1,1'b0,1'b0,2'b01, 2'b00,1'b0,6'h00,2'b01,1'b1,1'b0,1'b0};
    vt[6]  = '{2'b00,1'b1,1'b1,1'b0,1'b0,2'b01, 2'b00,1'b0,6'h00,2'b01,1'b1,1'b0,1'b0};
    vt[7]  = '{2'b00,1'b1,1'b1,1'b0,1'b1,2'b01, 2'b00,1'b0,6'h00,2'b01,1'b1,1'b0,1'b0};
    vt[8]  = '{2'b00,1'b1,1'b0,1'b0,1'b0,2'b00, 2'b00,1'b0,6'h00,2'b00,1'b0,1'b1,1'b0};
    vt[9]  = '{2'b00,1'b1,1'b1,1'b1,1'b0,2'b01, 2'b00,1'b0,6'h00,2'b10,1'b0,1'b1,1'b0};
    vt[10] = '{2'b00,1'b1,1'b0,1'b0,1'b0,2'b00, 2'b00,1'b0,6'h00,2'b00,1'b0,1'b1,1'b1};
    vt[11] = '{2'b11,1'b1,1'b0,1'b0,1'b0,2'b00, 2'b10,1'b0,6'h00,2'b00,1'b0,1'b1,1'b1};
    vt[12] = '{2'b11,1'b1,1'b0,1'b0,1'b0,2'b00, 2'b01,1'b1,6'h27,2'b00,1'b0,1'b0,1'b1};
    vt[13] = '{2'b11,1'b1,1'b0,1'b0,1'b0,2'b00, 2'b10,1'b1,6'h05,2'b00,1'b0,1'b0,1'b1};
    vt[14] = '{2'b00,1'b0,1'b0,1'b0,1'b0,2'b00, 2'b00,1'b1,6'h27,2'b00,1'b0,1'b0,1'b1};
    vt[15] = '{2'b01,1'b0,1'b0,1'b0,1'b0,2'b00, 2'b00,1'b1,6'h27,2'b00,1'b0,1'b0,1'b1};
    vt[16] = '{2'b01,1'b1,1'b0,1'b0,1'b0,2'b00, 2'b01,1'b1,6'h27,2'b00,1'b0,1'b0,1'b1};
    vt[17] = '{2'b00,1'b1,1'b0,1'b0,1'b0,2'b00, 2'b00,1'b1,6'h05,2'b00,1'b0,1'b0,1'b1};

    do_reset();
    for (int k = 0; k < 18; k++) begin
      @(posedge clk); #1;
      a_addr[0] = 32'h0000_1000; a_len[0] = 8'd3; a_size[0] = 3'd3; a_id[0] = 5'h05;
      a_addr[1] = 32'h0000_2000; a_len[1] = 8'd3; a_size[1] = 3'd3; a_id[1] = 5'h07;
      rid = 5'h05; rdata = 64'h0123_4567_89ab_cdef; rresp = 2'b00;
      m_ar_valid = vt[k].arv; s_ar_ready = vt[k].sar; s_r_valid = vt[k].rv;
      rsrc = vt[k].src; rlast = vt[k].lst; m_r_ready = vt[k].rrdy;
      #3;
      chk($sformatf("v%0d_m_ar_ready", k), 128'(m_ar_ready), 128'(vt[k].e_arr));
      chk($sformatf("v%0d_s_ar_valid", k), 128'(s_ar_valid), 128'(vt[k].e_sv));
      if (vt[k].e_sv) chk($sformatf("v%0d_s_ar_id", k), 128'(s_ar_bits[5:0]), 128'(vt[k].e_sid));
      chk($sformatf("v%0d_m_r_valid", k), 128'(m_r_valid), 128'(vt[k].e_rv));
      chk($sformatf("v%0d_s_r_ready", k), 128'(s_r_ready), 128'(vt[k].e_srr));
      chk($sformatf("v%0d_idle", k), 128'(idle), 128'(vt[k].e_idle));
      chk($sformatf("v%0d_err", k), 128'(err_unexpected_r), 128'(vt[k].e_err));
    end

    // outstanding limit: four bursts to requester 0, then requester 1 wins alone
    do_reset();
    for (int k = 0; k < 4; k++) cyc(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    cyc(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    cyc(2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01);
    cyc(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    // slave backpressure with both requesters waiting, then release
    for (int k = 0; k < 5; k++) cyc(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    for (int k = 0; k < 3; k++) cyc(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);

    // randomized traffic
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      logic [1:0] arv;
      logic sar, rv, src, lst;
      logic [1:0] rrdy;
      arv  = 2'($urandom);
      sar  = ($urandom_range(0, 9) < 7);
      rv   = ($urandom_range(0, 1) == 1);
      lst  = ($urandom_range(0, 2) == 0);
      rrdy = 2'($urandom);
      src  = 1'($urandom);
      if (rv && $urandom_range(0, 19) != 0) begin
        if (outst[0] == 0 && outst[1] == 0) rv = 1'b0;
        else if (outst[src] == 0) src = ~src;
      end
      cyc(arv, sar, rv, src, lst, rrdy);
    end
    @(posedge clk); #1;
    clear_inputs();
`ifdef NASTI_READ_ARB_PERF_EN
    #3;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("perf_grants%0d", i), 128'(perf_grants[i*32 +: 32]), 128'(grants_m[i]));
      chk($sformatf("perf_stall%0d", i), 128'(perf_stall[i*32 +: 32]), 128'(stalls_m[i]));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/nasti_read_arbiter.md
Name: nasti_read_arbiter

Overview:
- Shares the single FPGA-master read path into the Zynq HP slave port (AR/R channels, 64-bit data, 6-bit ID) between two NASTI read requesters, e.g. the shim's memory model and a DMA engine.
- Arbitrates AR round-robin through one output register stage.
- Tags each request's ID MSB with the source index and routes R beats back by that bit.
- Bounds outstanding bursts per requester.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 64, R data width.
- ID_W, 5, requester ID width; slave-side ID is ID_W+1.
- MAX_OUTSTANDING, 4, max in-flight AR bursts per requester (>=1).

Ports:
- clk  in  1  host clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- m_ar_valid  in  2  per-requester AR valid.
- m_ar_ready  out  2  per-requester AR ready.
- m_ar_bits  in  2*AR_W  AR_W=ADDR_W+8+3+ID_W; requester i at [i*AR_W +: AR_W]; fields MSB..LSB {addr,len,size,id}.
- m_r_valid  out  2  per-requester R valid.
- m_r_ready  in  2  per-requester R ready.
- m_r_bits  out  R_W  R_W=DATA_W+ID_W+3; {data,id,resp,last}; shared by both requesters, qualified by m_r_valid.
- s_ar_valid  out  1  slave AR valid (registered).
- s_ar_ready  in  1  slave AR ready.
- s_ar_bits  out  AR_W+1  {addr,len,size,{src,id}}.
- s_r_valid  in  1  slave R valid.
- s_r_ready  out  1  slave R ready.
- s_r_bits  in  R_W+1  {data,{src,id},resp,last}.
- idle  out  1  high when no AR is held and both outstanding counts are 0.
- err_unexpected_r  out  1  sticky R-routing error flag.

Behaviour:
- Reset (async, immediate):
  - s_ar_valid=0, s_ar_bits=0.
  - Counters cnt[0..1]=0, last_grant=1 (requester 0 wins first), err_unexpected_r=0, idle=1.
  - Reset mid-burst drops all state; no R tracking survives.
- Slot free: free = !s_ar_valid || s_ar_ready.
- Eligibility: elig[i] = m_ar_valid[i] && cnt[i] < MAX_OUTSTANDING.
- Grant (only when free):
  - Both eligible: grant requester != last_grant.
  - One eligible: grant it.
  - m_ar_ready[i] = free && grant==i (combinational). m_ar_ready=0 whenever the slot is not free.
- On an accepted grant, next edge:
  - s_ar_valid<=1; s_ar_bits<={addr,len,size,{i,id}}.
  - last_grant<=i; cnt[i]++.
- Back-to-back: throughput of one AR per cycle while s_ar_ready is held high.
- No grant while free: s_ar_valid<=0 on the edge where s_ar_ready=1.
- s_ar_bits is held stable while s_ar_valid && !s_ar_ready.
- Latency: requester AR handshake to s_ar_valid is 1 cycle.
- R routing (combinational pass-through, no buffering):
  - sel = s_r_bits ID MSB.
  - m_r_valid[sel] = s_r_valid; other requester's m_r_valid = 0.
  - s_r_ready = m_r_ready[sel].
  - m_r_bits = s_r_bits with the ID MSB removed.
- Completion: an R handshake with last=1 decrements cnt[sel].
- Simultaneous increment and decrement of the same counter: value unchanged.
- Counter width: clog2(MAX_OUTSTANDING+1), so it never wraps.
- Unexpected R: s_r_valid while cnt[sel]==0 sets err_unexpected_r (sticky until reset). The beat is still routed and the counter is not decremented.

Optional Feature:
- Macro: NASTI_READ_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_grants (2*32) and perf_stall (2*32).
  - perf_grants[i] counts accepted grants to requester i.
  - perf_stall[i] counts cycles where m_ar_valid[i] && !m_ar_ready[i].
  - All counters reset to 0 and wrap modulo 2^32.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then requester0 AR addr=0x0000_1000 len=3 id=5 -> next cycle s_ar_valid=1, s_ar_bits id=0x05, cnt0=1. Four R beats with id 0x05 reach requester0 only; cnt0=0 after last; idle=1.
- Both requesters valid continuously, s_ar_ready=1 -> grants 0,1,0,1,... one per cycle. s_ar id MSBs alternate 0,1.
- Requester0 issues 4 ARs with no R returned (MAX_OUTSTANDING=4):
  - 5th AR sees m_ar_ready[0]=0 while requester1 is still granted.
  - After one R last to requester0, the 5th AR is accepted the same cycle the slot is free.
- s_ar_ready=0 for 5 cycles with a held request -> s_ar_bits stable, m_ar_ready=0. Release -> held AR completes, next grant follows.
- R beat id 0x25 with m_r_ready[1]=0 -> s_r_ready=0, m_r_valid=2'b10. R to requester with cnt=0 -> err_unexpected_r=1 and stays 1.
- With NASTI_READ_ARB_PERF_EN: 3 grants to requester1 and 2 stalled cycles on requester0 -> perf_grants[1]=3, perf_stall[0]=2.
